// File: rtl/rv_pkg.sv
// Shared state encoding, RV32I major opcodes and trap causes for rv_multicycle_ctrl.
package rv_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

   function automatic logic is_legal(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
         OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_FENCE: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction/data memory request-ready handshake between the sequencer and the memories.
interface rv_multicycle_ctrl_if;
   logic imem_req;
   logic imem_rdy;
   logic dmem_req;
   logic dmem_we;
   logic dmem_rdy;

   modport master (output imem_req, dmem_req, dmem_we, input imem_rdy, dmem_rdy);
   modport slave  (input imem_req, dmem_req, dmem_we, output imem_rdy, dmem_rdy);
endinterface

// File: rtl/rv_wait_timer.sv
// Saturating wait-state counter; expired goes high once MEM_TIMEOUT wait cycles have elapsed.
module rv_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      cnt <= '0;
      else if (clear)               cnt <= '0;
      else if (inc && cnt != LIMIT) cnt <= cnt + 1'b1;
   end

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         assign expired = (cnt == LIMIT);
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with timeout and illegal-opcode trap.
// Optional performance counters are enabled by defining RV_MULTICYCLE_PERF_EN.
module rv_multicycle_ctrl
   import rv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [XLEN-1:0]      i_instr,
   input  logic                 i_br_taken,
   rv_multicycle_ctrl_if.master mem,
   output logic                 o_ir_en,
   output logic                 o_pc_en,
   output logic                 o_pc_sel,
   output logic                 o_rd_wren,
   output logic                 o_insn_vld,
   output logic [2:0]           o_state,
   output logic                 o_trap,
   output logic [1:0]           o_trap_cause
`ifdef RV_MULTICYCLE_PERF_EN
   ,
   output logic [CNT_W-1:0]     o_cycle_cnt,
   output logic [CNT_W-1:0]     o_instret_cnt
`endif
);
   state_e     state, state_nxt;
   logic [1:0] cause, cause_nxt;
   logic [6:0] opc;
   logic       waiting, rdy, expired;
   logic       unused_instr;

   assign opc          = i_instr[6:0];
   assign unused_instr = ^i_instr[XLEN-1:7];
   assign waiting      = (state == S_FETCH) || (state == S_MEM);
   assign rdy          = (state == S_FETCH) ? mem.imem_rdy : mem.dmem_rdy;

   // Counter is held at zero outside FETCH/MEM, so every entry starts a fresh count.
   rv_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (i_clk),
      .rst     (i_reset),
      .clear   (!waiting || rdy),
      .inc     (waiting && !rdy),
      .expired (expired)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= S_FETCH;
         cause <= CAUSE_NONE;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
      end
   end

   // NOTE: defaults at the top of each combinational block keep every path assigned (no latches).
   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      case (state)
         S_FETCH: begin
            if (mem.imem_rdy) state_nxt = S_DECODE;
            else if (expired) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_IMEM_TO;
            end
         end
         S_DECODE: begin
            if (is_legal(opc)) state_nxt = S_EXEC;
            else begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            case (opc)
               OPC_BRANCH, OPC_FENCE: state_nxt = S_FETCH;
               OPC_LOAD, OPC_STORE:   state_nxt = S_MEM;
               default:               state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem.dmem_rdy) state_nxt = (opc == OPC_STORE) ? S_FETCH : S_WB;
            else if (expired) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_DMEM_TO;
            end
         end
         S_WB:    state_nxt = S_FETCH;
         default: state_nxt = S_TRAP;
      endcase
   end

   // Requests and enables are forced low while reset is held, dropping any access in flight.
   always_comb begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      o_ir_en      = 1'b0;
      o_pc_en      = 1'b0;
      o_pc_sel     = 1'b0;
      o_rd_wren    = 1'b0;
      o_insn_vld   = 1'b0;
      if (!i_reset) begin
         case (state)
            S_FETCH: begin
               mem.imem_req = 1'b1;
               o_ir_en      = mem.imem_rdy;
            end
            S_EXEC: begin
               if (opc == OPC_BRANCH || opc == OPC_FENCE) begin
                  o_pc_en    = 1'b1;
                  o_insn_vld = 1'b1;
                  o_pc_sel   = (opc == OPC_BRANCH) && i_br_taken;
               end
            end
            S_MEM: begin
               mem.dmem_req = 1'b1;
               mem.dmem_we  = (opc == OPC_STORE);
               if (opc == OPC_STORE && mem.dmem_rdy) begin
                  o_pc_en    = 1'b1;
                  o_insn_vld = 1'b1;
               end
            end
            S_WB: begin
               o_rd_wren  = 1'b1;
               o_pc_en    = 1'b1;
               o_insn_vld = 1'b1;
               o_pc_sel   = (opc == OPC_JAL) || (opc == OPC_JALR);
            end
            default: ;
         endcase
      end
   end

   assign o_state      = state;
   assign o_trap       = (state == S_TRAP);
   assign o_trap_cause = cause;

`ifdef RV_MULTICYCLE_PERF_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_cycle_cnt   <= '0;
         o_instret_cnt <= '0;
      end else if (state != S_TRAP) begin
         o_cycle_cnt <= o_cycle_cnt + 1'b1;
         if (o_insn_vld) o_instret_cnt <= o_instret_cnt + 1'b1;
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed-vector bench for rv_multicycle_ctrl; perf-counter scenarios run when RV_MULTICYCLE_PERF_EN is defined.
module tb_rv_multicycle_ctrl;
   // Observation vector: {state[2:0], flags[8:0], cause[1:0]}
   // flags: imem_req, ir_en, dmem_req, dmem_we, pc_en, pc_sel, rd_wren, insn_vld, trap
   localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;
   localparam logic [8:0] FL_NONE   = 9'b000000000;
   localparam logic [8:0] FL_F_RDY  = 9'b110000000;
   localparam logic [8:0] FL_F_WAIT = 9'b100000000;
   localparam logic [8:0] FL_M_LD   = 9'b001000000;
   localparam logic [8:0] FL_M_ST   = 9'b001110010;
   localparam logic [8:0] FL_WB     = 9'b000010110;
   localparam logic [8:0] FL_WB_J   = 9'b000011110;
   localparam logic [8:0] FL_BR_T   = 9'b000011010;
   localparam logic [8:0] FL_BR_NT  = 9'b000010010;
   localparam logic [8:0] FL_TRAP   = 9'b000000001;

   localparam logic [31:0] I_ADD  = 32'h00B50533;
   localparam logic [31:0] I_LW   = 32'h0002A303;
   localparam logic [31:0] I_SW   = 32'h00B52023;
   localparam logic [31:0] I_JAL  = 32'h0000006F;
   localparam logic [31:0] I_BEQ  = 32'h00B50463;
   localparam logic [31:0] I_FEN  = 32'h0000000F;
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_br_taken = 1'b0;
   logic [31:0] i_instr = '0;
   logic        o_ir_en, o_pc_en, o_pc_sel, o_rd_wren, o_insn_vld, o_trap;
   logic [2:0]  o_state;
   logic [1:0]  o_trap_cause;
   logic [13:0] obs;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 i_clk = ~i_clk;

   rv_multicycle_ctrl_if mem_if ();

`ifdef RV_MULTICYCLE_PERF_EN
   logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif

   rv_multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_instr      (i_instr),
      .i_br_taken   (i_br_taken),
      .mem          (mem_if.master),
      .o_ir_en      (o_ir_en),
      .o_pc_en      (o_pc_en),
      .o_pc_sel     (o_pc_sel),
      .o_rd_wren    (o_rd_wren),
      .o_insn_vld   (o_insn_vld),
      .o_state      (o_state),
      .o_trap       (o_trap),
      .o_trap_cause (o_trap_cause)
`ifdef RV_MULTICYCLE_PERF_EN
      ,
      .o_cycle_cnt  (o_cycle_cnt),
      .o_instret_cnt(o_instret_cnt)
`endif
   );

`ifdef RV_MULTICYCLE_PERF_EN
   // Narrow-counter instance sharing the same stimulus, for the wrap check.
   rv_multicycle_ctrl_if mem4_if ();
   logic       w_ir_en, w_pc_en, w_pc_sel, w_rd_wren, w_insn_vld, w_trap;
   logic [2:0] w_state;
   logic [1:0] w_cause;
   logic [3:0] w_cycle_cnt, w_instret_cnt;
   assign mem4_if.imem_rdy = mem_if.imem_rdy;
   assign mem4_if.dmem_rdy = mem_if.dmem_rdy;

   rv_multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(4)) u_dut4 (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_instr      (i_instr),
      .i_br_taken   (i_br_taken),
      .mem          (mem4_if.master),
      .o_ir_en      (w_ir_en),
      .o_pc_en      (w_pc_en),
      .o_pc_sel     (w_pc_sel),
      .o_rd_wren    (w_rd_wren),
      .o_insn_vld   (w_insn_vld),
      .o_state      (w_state),
      .o_trap       (w_trap),
      .o_trap_cause (w_cause),
      .o_cycle_cnt  (w_cycle_cnt),
      .o_instret_cnt(w_instret_cnt)
   );
`endif

   assign obs = {o_state, mem_if.imem_req, o_ir_en, mem_if.dmem_req, mem_if.dmem_we,
                 o_pc_en, o_pc_sel, o_rd_wren, o_insn_vld, o_trap, o_trap_cause};

   function automatic logic [13:0] ev(input logic [2:0] st, input logic [8:0] fl, input logic [1:0] c);
      return {st, fl, c};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Leaves the DUT in cycle 1 (FETCH), 1 time unit after a rising edge.
   task automatic start(input logic [31:0] instr);
      i_instr = instr;
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
   endtask

   task automatic drive(input logic im, input logic dm, input logic br);
      mem_if.imem_rdy = im;
      mem_if.dmem_rdy = dm;
      i_br_taken      = br;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b1);
      i_reset = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         #1;
         n_cmp++;
         if (obs !== 14'd0) begin
            n_err++;
            $display("FAIL reset c%0d: got %h expected %h", c, obs, 14'd0);
         end
         tick();
      end
   endtask

   task automatic test_add();
      logic [13:0] exp [5];
      exp = '{ev(ST_F, FL_F_RDY, 0), ev(ST_D, FL_NONE, 0), ev(ST_E, FL_NONE, 0),
              ev(ST_W, FL_WB, 0), ev(ST_F, FL_F_RDY, 0)};
      start(I_ADD);
      for (int c = 1; c <= 5; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         #1;
         n_cmp++;
         if (obs !== exp[c-1]) begin
            n_err++;
            $display("FAIL add c%0d: got %h expected %h", c, obs, exp[c-1]);
         end
         tick();
      end
   endtask

   task automatic test_load_wait();
      logic [13:0] exp;
      start(I_LW);
      for (int c = 1; c <= 9; c++) begin
         drive(1'b1, c == 7, 1'b0);
         #1;
         if (c == 1 || c == 9)  exp = ev(ST_F, FL_F_RDY, 0);
         else if (c == 2)       exp = ev(ST_D, FL_NONE, 0);
         else if (c == 3)       exp = ev(ST_E, FL_NONE, 0);
         else if (c <= 7)       exp = ev(ST_M, FL_M_LD, 0);
         else                   exp = ev(ST_W, FL_WB, 0);
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL load_wait c%0d: got %h expected %h", c, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_store();
      logic [13:0] exp [5];
      exp = '{ev(ST_F, FL_F_RDY, 0), ev(ST_D, FL_NONE, 0), ev(ST_E, FL_NONE, 0),
              ev(ST_M, FL_M_ST, 0), ev(ST_F, FL_F_RDY, 0)};
      start(I_SW);
      for (int c = 1; c <= 5; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         #1;
         n_cmp++;
         if (obs !== exp[c-1]) begin
            n_err++;
            $display("FAIL store c%0d: got %h expected %h", c, obs, exp[c-1]);
         end
         tick();
      end
   endtask

   task automatic test_jal();
      logic [13:0] exp [5];
      exp = '{ev(ST_F, FL_F_RDY, 0), ev(ST_D, FL_NONE, 0), ev(ST_E, FL_NONE, 0),
              ev(ST_W, FL_WB_J, 0), ev(ST_F, FL_F_RDY, 0)};
      start(I_JAL);
      for (int c = 1; c <= 5; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         #1;
         n_cmp++;
         if (obs !== exp[c-1]) begin
            n_err++;
            $display("FAIL jal c%0d: got %h expected %h", c, obs, exp[c-1]);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      logic [13:0] exp;
      for (int t = 1; t >= 0; t--) begin
         start(I_BEQ);
         for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b1, t[0]);
            #1;
            if (c == 1 || c == 4) exp = ev(ST_F, FL_F_RDY, 0);
            else if (c == 2)      exp = ev(ST_D, FL_NONE, 0);
            else                  exp = ev(ST_E, t[0] ? FL_BR_T : FL_BR_NT, 0);
            n_cmp++;
            if (obs !== exp) begin
               n_err++;
               $display("FAIL branch taken=%0d c%0d: got %h expected %h", t, c, obs, exp);
            end
            if (c == 3 && t == 0) begin
               i_br_taken = 1'b1;
               #1;
               n_cmp++;
               if (o_pc_sel !== 1'b1) begin
                  n_err++;
                  $display("FAIL branch pc_sel follow: got %b expected 1", o_pc_sel);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_fence();
      logic [13:0] exp [4];
      exp = '{ev(ST_F, FL_F_RDY, 0), ev(ST_D, FL_NONE, 0), ev(ST_E, FL_BR_NT, 0),
              ev(ST_F, FL_F_RDY, 0)};
      start(I_FEN);
      for (int c = 1; c <= 4; c++) begin
         drive(1'b1, 1'b1, 1'b1);
         #1;
         n_cmp++;
         if (obs !== exp[c-1]) begin
            n_err++;
            $display("FAIL fence c%0d: got %h expected %h", c, obs, exp[c-1]);
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      logic [13:0] exp;
      start(I_ILL);
      for (int c = 1; c <= 8; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         #1;
         if (c == 1)      exp = ev(ST_F, FL_F_RDY, 0);
         else if (c == 2) exp = ev(ST_D, FL_NONE, 0);
         else             exp = ev(ST_T, FL_TRAP, 1);
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL illegal c%0d: got %h expected %h", c, obs, exp);
         end
         tick();
      end
      i_reset = 1'b1;
      #1;
      n_cmp++;
      if (obs !== 14'd0) begin
         n_err++;
         $display("FAIL illegal in_reset: got %h expected %h", obs, 14'd0);
      end
      tick();
      i_reset = 1'b0;
      #1;
      n_cmp++;
      if (obs !== ev(ST_F, FL_F_RDY, 0)) begin
         n_err++;
         $display("FAIL illegal after_reset: got %h expected %h", obs, ev(ST_F, FL_F_RDY, 0));
      end
   endtask

   task automatic test_timeout_imem();
      logic [13:0] exp;
      for (int late = 0; late <= 1; late++) begin
         start(I_ADD);
         for (int c = 1; c <= 18; c++) begin
            drive(late == 1 && c == 17, 1'b1, 1'b0);
            #1;
            if (c < 17)            exp = ev(ST_F, FL_F_WAIT, 0);
            else if (late == 0)    exp = (c == 17) ? ev(ST_F, FL_F_WAIT, 0) : ev(ST_T, FL_TRAP, 2);
            else                   exp = (c == 17) ? ev(ST_F, FL_F_RDY, 0) : ev(ST_D, FL_NONE, 0);
            n_cmp++;
            if (obs !== exp) begin
               n_err++;
               $display("FAIL imem_timeout late_rdy=%0d c%0d: got %h expected %h", late, c, obs, exp);
            end
            tick();
         end
      end
   endtask

   task automatic test_timeout_dmem();
      logic [13:0] exp;
      start(I_LW);
      for (int c = 1; c <= 22; c++) begin
         drive(1'b1, 1'b0, 1'b0);
         #1;
         if (c == 1)       exp = ev(ST_F, FL_F_RDY, 0);
         else if (c == 2)  exp = ev(ST_D, FL_NONE, 0);
         else if (c == 3)  exp = ev(ST_E, FL_NONE, 0);
         else if (c <= 20) exp = ev(ST_M, FL_M_LD, 0);
         else              exp = ev(ST_T, FL_TRAP, 3);
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL dmem_timeout c%0d: got %h expected %h", c, obs, exp);
         end
         tick();
      end
   endtask

`ifdef RV_MULTICYCLE_PERF_EN
   task automatic test_perf();
      start(I_ADD);
      drive(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 40; c++) tick();
      #1;
      n_cmp++;
      if ({o_instret_cnt, o_cycle_cnt} !== {32'd10, 32'd40}) begin
         n_err++;
         $display("FAIL perf_10: got instret=%0d cycle=%0d expected 10/40", o_instret_cnt, o_cycle_cnt);
      end
      n_cmp++;
      if ({w_instret_cnt, w_cycle_cnt} !== {4'd10, 4'd8}) begin
         n_err++;
         $display("FAIL perf4_10: got instret=%0d cycle=%0d expected 10/8", w_instret_cnt, w_cycle_cnt);
      end
      for (int c = 0; c < 24; c++) tick();
      #1;
      n_cmp++;
      if ({o_instret_cnt, o_cycle_cnt} !== {32'd16, 32'd64}) begin
         n_err++;
         $display("FAIL perf_16: got instret=%0d cycle=%0d expected 16/64", o_instret_cnt, o_cycle_cnt);
      end
      n_cmp++;
      if ({w_instret_cnt, w_cycle_cnt} !== {4'd0, 4'd0}) begin
         n_err++;
         $display("FAIL perf4_wrap: got instret=%0d cycle=%0d expected 0/0", w_instret_cnt, w_cycle_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mem_if.imem_rdy = 1'b0;
      mem_if.dmem_rdy = 1'b0;
      tick();
      test_reset();
      test_add();
      test_load_wait();
      test_store();
      test_jal();
      test_branch();
      test_fence();
      test_illegal();
      test_timeout_imem();
      test_timeout_dmem();
`ifdef RV_MULTICYCLE_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
